// File: rtl/am29_bitslice_core.sv
// am29_bitslice_core: one 4-bit Am2901-style ALU slice plus one 4-bit
// Am2909/Am2911-style microprogram sequencer slice. The two halves share
// only clock and reset, and are cascaded externally through their carries.
module am29_bitslice_core #(
  parameter int AM2911_MODE = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] alu_din,
  input  logic [3:0] alu_a,
  input  logic [3:0] alu_b,
  input  logic [2:0] alu_src,
  input  logic [2:0] alu_op,
  input  logic [2:0] alu_dest,
  input  logic       alu_cin,
  output logic [3:0] alu_y,
  output logic       alu_cout,
  output logic       alu_f0,
  output logic       alu_f3,
  output logic       alu_ovr,
  input  logic [3:0] seq_din,
  input  logic [3:0] seq_rin,
  input  logic [3:0] seq_orin,
  input  logic       seq_s0,
  input  logic       seq_s1,
  input  logic       seq_zero,
  input  logic       seq_cin,
  input  logic       seq_re,
  input  logic       seq_fe,
  input  logic       seq_pup,
  output logic [3:0] seq_y,
  output logic       seq_cout
);

  localparam logic IS_2911 = (AM2911_MODE != 0);

  // ---------------- ALU slice ----------------
  logic [3:0] ram_q [16];
  logic [3:0] q_q, q_d;
  logic       ram_we_d;
  logic [3:0] ram_wdata_d;
  logic [3:0] a_val, b_val, r_val, s_val;
  logic [3:0] r_op, s_op, f_val;
  logic [4:0] sum_full;
  logic       arith;

  // Register file read ports and R/S operand selection
  always_comb begin
    a_val = ram_q[alu_a];
    b_val = ram_q[alu_b];
    r_val = '0;
    s_val = '0;
    case (alu_src)
      3'd0: begin r_val = a_val;   s_val = q_q;   end
      3'd1: begin r_val = a_val;   s_val = b_val; end
      3'd2: begin r_val = '0;      s_val = q_q;   end
      3'd3: begin r_val = '0;      s_val = b_val; end
      3'd4: begin r_val = '0;      s_val = a_val; end
      3'd5: begin r_val = alu_din; s_val = a_val; end
      3'd6: begin r_val = alu_din; s_val = q_q;   end
      default: begin r_val = alu_din; s_val = '0; end
    endcase
  end

  // ALU function; subtraction is done by inverting one operand into the adder
  always_comb begin
    r_op  = r_val;
    s_op  = s_val;
    f_val = '0;
    arith = 1'b0;
    case (alu_op)
      3'd0: arith = 1'b1;
      3'd1: begin r_op = ~r_val; arith = 1'b1; end
      3'd2: begin s_op = ~s_val; arith = 1'b1; end
      3'd3: f_val = r_val | s_val;
      3'd4: f_val = r_val & s_val;
      3'd5: f_val = ~r_val & s_val;
      3'd6: f_val = r_val ^ s_val;
      default: f_val = ~(r_val ^ s_val);
    endcase
    sum_full = {1'b0, r_op} + {1'b0, s_op} + {4'b0000, alu_cin};
    if (arith) begin
      f_val = sum_full[3:0];
    end
    alu_cout = arith & sum_full[4];
    // carry into bit 3 recovered from the sum bit and the two operand bits
    alu_ovr  = arith & ((sum_full[3] ^ r_op[3] ^ s_op[3]) ^ sum_full[4]);
  end

  assign alu_f0 = (f_val == 4'h0);
  assign alu_f3 = f_val[3];

  // Destination decode: Y source, RAM write data and Q next value
  always_comb begin
    q_d         = q_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = f_val;
    alu_y       = f_val;
    case (alu_dest)
      3'd0: q_d = f_val;
      3'd2: begin ram_we_d = 1'b1; alu_y = a_val; end
      3'd3: ram_we_d = 1'b1;
      3'd4: begin
        ram_we_d    = 1'b1;
        ram_wdata_d = {1'b0, f_val[3:1]};
        q_d         = {1'b0, q_q[3:1]};
      end
      3'd5: begin
        ram_we_d    = 1'b1;
        ram_wdata_d = {1'b0, f_val[3:1]};
      end
      3'd6: begin
        ram_we_d    = 1'b1;
        ram_wdata_d = {f_val[2:0], 1'b0};
        q_d         = {q_q[2:0], 1'b0};
      end
      3'd7: begin
        ram_we_d    = 1'b1;
        ram_wdata_d = {f_val[2:0], 1'b0};
      end
      default: ;
    endcase
  end

  // ALU register file and Q register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        ram_q[i] <= '0;
      end
      q_q <= '0;
    end else begin
      q_q <= q_d;
      if (ram_we_d) begin
        ram_q[alu_b] <= ram_wdata_d;
      end
    end
  end

  // ---------------- Sequencer slice ----------------
  logic [3:0] upc_q, upc_d;
  logic [3:0] ar_q, ar_d;
  logic [1:0] sp_q, sp_d;
  logic [3:0] stack_q [4];
  logic       stack_we_d;
  logic [1:0] stack_waddr;
  logic [3:0] mux_val, or_val, incr;

  // Address source mux, OR/zero gating and incrementer
  always_comb begin
    case ({seq_s1, seq_s0})
      2'd0:    mux_val = upc_q;
      2'd1:    mux_val = ar_q;
      2'd2:    mux_val = stack_q[sp_q];
      default: mux_val = seq_din;
    endcase
    or_val = IS_2911 ? 4'h0 : seq_orin;
    seq_y  = (mux_val | or_val) & {4{seq_zero}};
    {seq_cout, incr} = {1'b0, seq_y} + {4'b0000, seq_cin};
  end

  // Next state for uPC, address register and stack pointer
  always_comb begin
    upc_d       = incr;
    ar_d        = ar_q;
    sp_d        = sp_q;
    stack_we_d  = 1'b0;
    stack_waddr = sp_q + 2'd1;
    if (!seq_re) begin
      ar_d = IS_2911 ? seq_din : seq_rin;
    end
    if (!seq_fe) begin
      if (seq_pup) begin
        sp_d       = sp_q + 2'd1;
        stack_we_d = 1'b1;
      end else begin
        sp_d = sp_q - 2'd1;
      end
    end
  end

  // Sequencer registers; a push stores the pre-edge uPC
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      upc_q <= '0;
      ar_q  <= '0;
      sp_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      upc_q <= upc_d;
      ar_q  <= ar_d;
      sp_q  <= sp_d;
      if (stack_we_d) begin
        stack_q[stack_waddr] <= upc_q;
      end
    end
  end

endmodule

// File: tb/tb_am29_bitslice_core.sv
// tb_am29_bitslice_core: drives one Am2901/Am2909 instance and one Am2911
// instance with identical inputs and compares both against a plain
// arithmetic reference model of the slice behaviour.
module tb_am29_bitslice_core;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] alu_din = '0, alu_a = '0, alu_b = '0;
  logic [2:0] alu_src = '0, alu_op = '0, alu_dest = '0;
  logic       alu_cin = 1'b0;
  logic [3:0] seq_din = '0, seq_rin = '0, seq_orin = '0;
  logic       seq_s0 = 1'b0, seq_s1 = 1'b0, seq_zero = 1'b0, seq_cin = 1'b0;
  logic       seq_re = 1'b0, seq_fe = 1'b0, seq_pup = 1'b0;

  logic [3:0] alu_y0, alu_y1, seq_y0, seq_y1;
  logic       alu_cout0, alu_f00, alu_f30, alu_ovr0, seq_cout0;
  logic       alu_cout1, alu_f01, alu_f31, alu_ovr1, seq_cout1;

  int check_count = 0;
  int pass_count = 0;

  // reference model state, index 0 = Am2909 instance, 1 = Am2911 instance
  int m_ram[16];
  int m_q;
  int m_upc[2], m_ar[2], m_sp[2];
  int m_stk[2][4];

  am29_bitslice_core #(.AM2911_MODE(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n),
    .alu_din(alu_din), .alu_a(alu_a), .alu_b(alu_b), .alu_src(alu_src),
    .alu_op(alu_op), .alu_dest(alu_dest), .alu_cin(alu_cin),
    .alu_y(alu_y0), .alu_cout(alu_cout0), .alu_f0(alu_f00), .alu_f3(alu_f30),
    .alu_ovr(alu_ovr0),
    .seq_din(seq_din), .seq_rin(seq_rin), .seq_orin(seq_orin),
    .seq_s0(seq_s0), .seq_s1(seq_s1), .seq_zero(seq_zero), .seq_cin(seq_cin),
    .seq_re(seq_re), .seq_fe(seq_fe), .seq_pup(seq_pup),
    .seq_y(seq_y0), .seq_cout(seq_cout0)
  );

  am29_bitslice_core #(.AM2911_MODE(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n),
    .alu_din(alu_din), .alu_a(alu_a), .alu_b(alu_b), .alu_src(alu_src),
    .alu_op(alu_op), .alu_dest(alu_dest), .alu_cin(alu_cin),
    .alu_y(alu_y1), .alu_cout(alu_cout1), .alu_f0(alu_f01), .alu_f3(alu_f31),
    .alu_ovr(alu_ovr1),
    .seq_din(seq_din), .seq_rin(seq_rin), .seq_orin(seq_orin),
    .seq_s0(seq_s0), .seq_s1(seq_s1), .seq_zero(seq_zero), .seq_cin(seq_cin),
    .seq_re(seq_re), .seq_fe(seq_fe), .seq_pup(seq_pup),
    .seq_y(seq_y1), .seq_cout(seq_cout1)
  );

  // free-running clock, period 10
  always #5 clock = ~clock;

  function automatic int sgn(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
  endtask

  task automatic resetModel();
    for (int i = 0; i < 16; i++) m_ram[i] = 0;
    m_q = 0;
    for (int m = 0; m < 2; m++) begin
      m_upc[m] = 0; m_ar[m] = 0; m_sp[m] = 0;
      for (int i = 0; i < 4; i++) m_stk[m][i] = 0;
    end
  endtask

  task automatic setIdle();
    alu_din = 0; alu_a = 0; alu_b = 0; alu_src = 0; alu_op = 0;
    alu_dest = 3'd1; alu_cin = 0;
    seq_din = 0; seq_rin = 0; seq_orin = 0; seq_s0 = 0; seq_s1 = 0;
    seq_zero = 1; seq_cin = 0; seq_re = 1; seq_fe = 1; seq_pup = 0;
  endtask

  // Called at a falling edge with inputs set: checks outputs, then advances
  // the model across the next rising edge.
  task automatic applyStimulus();
    int av, bv, r, s, t, sv, f, yv, co, ov, wb, wdata, nq;
    bit we;
    int mv, orv, sy, sc;
    int n_upc[2], n_ar[2], n_sp[2], push_val[2];
    bit push;
    #1;
    av = m_ram[alu_a];
    bv = m_ram[alu_b];
    case (alu_src)
      3'd0: begin r = av; s = m_q; end
      3'd1: begin r = av; s = bv; end
      3'd2: begin r = 0; s = m_q; end
      3'd3: begin r = 0; s = bv; end
      3'd4: begin r = 0; s = av; end
      3'd5: begin r = alu_din; s = av; end
      3'd6: begin r = alu_din; s = m_q; end
      default: begin r = alu_din; s = 0; end
    endcase
    co = 0; ov = 0; t = 0; sv = 0;
    case (alu_op)
      3'd0: begin t = r + s + alu_cin;        sv = sgn(r) + sgn(s) + alu_cin; end
      3'd1: begin t = s + (15 - r) + alu_cin; sv = sgn(s) - sgn(r) - 1 + alu_cin; end
      3'd2: begin t = r + (15 - s) + alu_cin; sv = sgn(r) - sgn(s) - 1 + alu_cin; end
      3'd3: t = r | s;
      3'd4: t = r & s;
      3'd5: t = (15 - r) & s;
      3'd6: t = r ^ s;
      default: t = 15 - (r ^ s);
    endcase
    f = t % 16;
    if (alu_op <= 3'd2) begin
      co = t / 16;
      ov = (sv > 7 || sv < -8) ? 1 : 0;
    end
    yv = (alu_dest == 3'd2) ? av : f;
    checkOutput("alu_y", alu_y0, yv);
    checkOutput("alu_cout", alu_cout0, co);
    checkOutput("alu_f0", alu_f00, (f == 0) ? 1 : 0);
    checkOutput("alu_f3", alu_f30, f / 8);
    checkOutput("alu_ovr", alu_ovr0, ov);
    checkOutput("alu_y_2911", alu_y1, yv);

    we = (alu_dest >= 3'd2);
    wb = alu_b;
    nq = m_q;
    wdata = f;
    if (alu_dest == 3'd0) nq = f;
    if (alu_dest == 3'd4 || alu_dest == 3'd5) wdata = f / 2;
    if (alu_dest == 3'd6 || alu_dest == 3'd7) wdata = (f * 2) % 16;
    if (alu_dest == 3'd4) nq = m_q / 2;
    if (alu_dest == 3'd6) nq = (m_q * 2) % 16;

    push = !seq_fe && seq_pup;
    for (int m = 0; m < 2; m++) begin
      case ({seq_s1, seq_s0})
        2'd0: mv = m_upc[m];
        2'd1: mv = m_ar[m];
        2'd2: mv = m_stk[m][m_sp[m]];
        default: mv = seq_din;
      endcase
      orv = (m == 1) ? 0 : seq_orin;
      sy = seq_zero ? (mv | orv) : 0;
      sc = sy + seq_cin;
      checkOutput($sformatf("seq_y_m%0d", m), (m == 1) ? seq_y1 : seq_y0, sy);
      checkOutput($sformatf("seq_cout_m%0d", m), (m == 1) ? seq_cout1 : seq_cout0, sc / 16);
      n_upc[m] = sc % 16;
      n_ar[m] = m_ar[m];
      if (!seq_re) n_ar[m] = (m == 1) ? seq_din : seq_rin;
      n_sp[m] = m_sp[m];
      push_val[m] = m_upc[m];
      if (!seq_fe) n_sp[m] = seq_pup ? (m_sp[m] + 1) % 4 : (m_sp[m] + 3) % 4;
    end

    @(posedge clock);
    if (we) m_ram[wb] = wdata;
    m_q = nq;
    for (int m = 0; m < 2; m++) begin
      m_upc[m] = n_upc[m];
      m_ar[m] = n_ar[m];
      m_sp[m] = n_sp[m];
      if (push) m_stk[m][n_sp[m]] = push_val[m];
    end
    @(negedge clock);
  endtask

  // asynchronous reset pulse between clock edges
  task automatic applyReset();
    reset_n = 0;
    #1;
    resetModel();
    reset_n = 1;
  endtask

  initial begin
    int exp_pop[5];
    resetModel();
    #2;
    checkOutput("rst_alu_y", alu_y0, 0);
    checkOutput("rst_alu_y_2911", alu_y1, 0);
    checkOutput("rst_seq_y", seq_y0, 0);
    checkOutput("rst_seq_y_2911", seq_y1, 0);
    @(negedge clock);
    reset_n = 1;
    setIdle();

    // D passthrough into RAM[5], then 0 + B + cin
    alu_src = 3'd7; alu_op = 3'd3; alu_dest = 3'd3; alu_b = 4'd5; alu_din = 4'd9;
    #1 checkOutput("t1_y_d", alu_y0, 9);
    applyStimulus();
    alu_src = 3'd3; alu_op = 3'd0; alu_dest = 3'd1; alu_cin = 1;
    #1 checkOutput("t1_y_sum", alu_y0, 4'hA);
    checkOutput("t1_cout", alu_cout0, 0);
    checkOutput("t1_f0", alu_f00, 0);
    applyStimulus();

    // 7 + 1 overflows, then F + 1 wraps to zero with carry
    alu_src = 3'd7; alu_op = 3'd3; alu_dest = 3'd3; alu_b = 4'd1; alu_din = 4'd1; alu_cin = 0;
    applyStimulus();
    alu_src = 3'd5; alu_din = 4'd7; alu_a = 4'd1; alu_op = 3'd0; alu_dest = 3'd1;
    #1 checkOutput("t2_y", alu_y0, 8);
    checkOutput("t2_f3", alu_f30, 1);
    checkOutput("t2_ovr", alu_ovr0, 1);
    checkOutput("t2_cout", alu_cout0, 0);
    applyStimulus();
    alu_din = 4'hF;
    #1 checkOutput("t2_wrap_y", alu_y0, 0);
    checkOutput("t2_wrap_cout", alu_cout0, 1);
    checkOutput("t2_wrap_f0", alu_f00, 1);
    applyStimulus();

    // S - R with equal operands, then shift-right destination
    alu_src = 3'd7; alu_op = 3'd3; alu_dest = 3'd3; alu_b = 4'd3; alu_din = 4'd3;
    applyStimulus();
    alu_src = 3'd5; alu_a = 4'd3; alu_op = 3'd1; alu_cin = 1; alu_dest = 3'd1;
    #1 checkOutput("t3_sub_y", alu_y0, 0);
    checkOutput("t3_sub_cout", alu_cout0, 1);
    checkOutput("t3_sub_f0", alu_f00, 1);
    applyStimulus();
    alu_src = 3'd7; alu_din = 4'd4; alu_op = 3'd3; alu_dest = 3'd0; alu_cin = 0;
    applyStimulus();
    alu_din = 4'd6; alu_dest = 3'd4; alu_b = 4'd2;
    #1 checkOutput("t3_shr_y", alu_y0, 6);
    applyStimulus();
    alu_src = 3'd4; alu_a = 4'd2; alu_op = 3'd0; alu_dest = 3'd1;
    #1 checkOutput("t3_ram_shr", alu_y0, 3);
    applyStimulus();
    alu_src = 3'd2;
    #1 checkOutput("t3_q_shr", alu_y0, 2);
    applyStimulus();

    // sequencer D path with carry out, uPC wrap, zero forcing
    setIdle();
    seq_s1 = 1; seq_s0 = 1; seq_din = 4'hF; seq_cin = 1;
    #1 checkOutput("t4_y", seq_y0, 4'hF);
    checkOutput("t4_cout", seq_cout0, 1);
    applyStimulus();
    seq_s1 = 0; seq_s0 = 0; seq_cin = 0;
    #1 checkOutput("t4_upc_wrap", seq_y0, 0);
    applyStimulus();
    seq_s1 = 1; seq_s0 = 1; seq_din = 4'd5; seq_zero = 0;
    #1 checkOutput("t4_zero", seq_y0, 0);
    checkOutput("t4_zero_2911", seq_y1, 0);
    applyStimulus();

    // push uPC=5 and read it back, then pop and overflow the stack
    seq_zero = 1; seq_din = 4'd4; seq_cin = 1;
    applyStimulus();
    seq_s1 = 0; seq_s0 = 0; seq_cin = 0; seq_fe = 0; seq_pup = 1;
    applyStimulus();
    seq_fe = 1; seq_s1 = 1; seq_s0 = 0;
    #1 checkOutput("t5_top", seq_y0, 5);
    applyStimulus();
    seq_fe = 0; seq_pup = 0;
    applyStimulus();
    for (int v = 1; v <= 6; v++) begin
      seq_s1 = 1; seq_s0 = 1; seq_din = 4'(v);
      seq_fe = (v == 1); seq_pup = 1;
      applyStimulus();
    end
    exp_pop = '{5, 4, 3, 2, 5};
    seq_s1 = 1; seq_s0 = 0; seq_fe = 0; seq_pup = 0;
    for (int i = 0; i < 5; i++) begin
      #1 checkOutput($sformatf("t5_pop%0d", i), seq_y0, exp_pop[i]);
      applyStimulus();
    end
    seq_fe = 1;

    // AR load visible next cycle; Am2911 loads D and ignores OR
    seq_s1 = 0; seq_s0 = 1; seq_re = 0; seq_rin = 4'hA; seq_din = 4'd3; seq_orin = 0;
    #1 checkOutput("t6_ar_old", seq_y0, 0);
    checkOutput("t6_ar_old_2911", seq_y1, 0);
    applyStimulus();
    seq_re = 1;
    #1 checkOutput("t6_ar_new", seq_y0, 4'hA);
    checkOutput("t6_ar_new_2911", seq_y1, 3);
    applyStimulus();
    seq_orin = 4'hF;
    #1 checkOutput("t6_or_2911", seq_y1, 3);
    checkOutput("t6_or_2909", seq_y0, 4'hF);
    applyStimulus();

    // randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) applyReset();
      alu_din = 4'($urandom); alu_a = 4'($urandom); alu_b = 4'($urandom);
      alu_src = 3'($urandom); alu_op = 3'($urandom); alu_dest = 3'($urandom);
      alu_cin = 1'($urandom);
      seq_din = 4'($urandom); seq_rin = 4'($urandom);
      seq_orin = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      seq_s0 = 1'($urandom); seq_s1 = 1'($urandom);
      seq_zero = ($urandom_range(0, 7) != 0);
      seq_cin = 1'($urandom);
      seq_re = ($urandom_range(0, 3) != 0);
      seq_fe = ($urandom_range(0, 2) != 0);
      seq_pup = 1'($urandom);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/am29_bitslice_core.md
Name: am29_bitslice_core

Overview:
- One 4-bit Am2901-compatible ALU slice and one 4-bit Am2909/Am2911-compatible microprogram sequencer slice in a single block.
- The two halves share only the clock and reset.
- Instances are cascaded (ALU carry chain; sequencer carry chain) to build the CPU6 8-bit datapath and 11-bit microcode address.
- A parameter selects Am2911 mode (no separate R input, no OR inputs).

Parameters:
- AM2911_MODE, 0: when 1, the address register loads from seq_din, and seq_rin/seq_orin are ignored.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- alu_din  in  4  ALU direct data D
- alu_a  in  4  register-file A address
- alu_b  in  4  register-file B address
- alu_src  in  3  source select I2:0
- alu_op  in  3  function select I5:3
- alu_dest  in  3  destination select I8:6
- alu_cin  in  1  carry in
- alu_y  out  4  Y output
- alu_cout  out  1  carry out
- alu_f0  out  1  high when F==0
- alu_f3  out  1  F[3] (sign)
- alu_ovr  out  1  overflow
- seq_din  in  4  direct input D
- seq_rin  in  4  AR load data
- seq_orin  in  4  OR inputs
- seq_s0  in  1  source select bit 0
- seq_s1  in  1  source select bit 1
- seq_zero  in  1  active-low; forces Y to 0
- seq_cin  in  1  incrementer carry in
- seq_re  in  1  active-low AR load enable
- seq_fe  in  1  active-low stack file enable
- seq_pup  in  1  1 = push, 0 = pop
- seq_y  out  4  microaddress output
- seq_cout  out  1  incrementer carry out

Behaviour:
- Reset (reset_n=0, async): clears ALU RAM[0..15], Q, uPC, AR, SP and all 4 stack words to 0.
- Outputs stay combinational during reset. With all control inputs at 0, seq_y=0 and alu_y=0.

ALU:
- Operands, by alu_src: 0 R=A,S=Q; 1 A,B; 2 0,Q; 3 0,B; 4 0,A; 5 D,A; 6 D,Q; 7 D,0.
- A and B are RAM reads, combinational from the current addresses.
- Function, by alu_op:
  - 0 F=R+S+cin
  - 1 F=S+~R+cin
  - 2 F=R+~S+cin
  - 3 R|S
  - 4 R&S
  - 5 ~R&S
  - 6 R^S
  - 7 ~(R^S)
- Arithmetic (ops 0-2): cout = 5th sum bit; ovr = carry into bit3 XOR cout.
- Logic (ops 3-7): cout=0 and ovr=0.
- f0 = (F==4'h0); f3 = F[3].
- Destination, by alu_dest; writes occur at the rising clock:
  - 0 Q<=F, Y=F
  - 1 no write, Y=F
  - 2 RAM[B]<=F, Y=A
  - 3 RAM[B]<=F, Y=F
  - 4 RAM[B]<=F>>1, Q<=Q>>1, Y=F
  - 5 RAM[B]<=F>>1, Y=F
  - 6 RAM[B]<=F<<1, Q<=Q<<1, Y=F
  - 7 RAM[B]<=F<<1, Y=F
- All shift-in bits are 0 (no shift pins).
- Source operands are sampled before the edge, so read-modify-write of RAM[B] in one cycle is legal.

Sequencer:
- Mux by {s1,s0}: 0 uPC, 1 AR, 2 stack[SP], 3 D.
- seq_y = (mux | ORin) & {4{seq_zero}}. ORin = seq_orin, or 0 in AM2911_MODE.
- {seq_cout, incr} = seq_y + seq_cin. The uPC loads incr every clock.
- seq_cout = 1 only when seq_y==4'hF and seq_cin=1.
- seq_re=0: AR loads at the edge (seq_rin, or seq_din in AM2911_MODE). The new AR is visible next cycle.
- seq_fe=0, pup=1 (push): SP<=SP+1; stack[SP+1]<=current uPC (value before this edge).
- seq_fe=0, pup=0 (pop): SP<=SP-1.
- seq_fe=1: stack and SP hold.
- SP is 2 bits and wraps silently (5th push overwrites the oldest entry; pop at SP=0 goes to 3).
- Selecting the stack in the same cycle as a push or pop outputs the pre-edge top.
- Asserting seq_zero=0 does not suppress register updates. The uPC loads seq_cin.

Test Plan:
1. Reset, then release; ALU src=7 (D,0), op=3, dest=3, B=5, D=9 → Y=9 and RAM[5]=9. Then src=3 (0,B), op=0, cin=1 → Y=A, cout=0, f0=0.
2. ALU R=7,S=1 via src=5, op=0, cin=0 → F=8, f3=1, ovr=1, cout=0. Then D=F, S=1 → F=0, cout=1, f0=1.
3. ALU op=1, src=5, R=3, S=3, cin=1 → F=0, cout=1, f0=1. Then dest=4 with F=6, Q=4 → RAM[B]=3, Q=2, Y=6.
4. Sequencer s=3, D=0xF, cin=1 → Y=F, cout=1; next cycle s=0 → Y=0. With zero=0 → Y=0 regardless of mux.
5. Sequencer: uPC=5, push (fe=0, pup=1); next cycle s=2 → Y=5. Pop, then 5 pushes of values 1..5 → top reads 5 and the oldest entry is overwritten (SP wrap).
6. re=0 with rin=0xA, s=1 the same cycle → Y=old AR (0), then 0xA. AM2911_MODE=1: AR loads din; orin=0xF has no effect.
